// File: rtl/spi_multichannel_transmitter.sv
// rtl/spi_multichannel_transmitter.sv - FIFO-fed SPI frame transmitter with per-channel frame selects
module spi_multichannel_transmitter #(
    parameter int WORD_WIDTH = 24,
    parameter int CLK_DIV    = 1,
    parameter int NUM_CH     = 2,
    parameter int CPOL       = 1,
    parameter int LSB_FIRST  = 0,
    parameter int SYNC_GAP   = 2,
    localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [CH_BITS+WORD_WIDTH-1:0] data,
    input  logic                          fifo_empty,
    output logic                          fifo_read,
    input  logic                          start_transmit,
    output logic                          spi_busy,
    output logic                          frame_done,
    output logic                          chan_error,
    output logic                          sdo,
    output logic                          sclk,
    output logic [NUM_CH-1:0]             sync_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic               CPOL_B   = (CPOL != 0);
    localparam logic [8:0]         HALF_CNT = 9'(CLK_DIV);
    localparam logic [8:0]         LAST_CYC = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0]         LAST_BIT = 6'(WORD_WIDTH - 1);
    localparam logic [3:0]         GAP_LAST = 4'(SYNC_GAP - 1);
    localparam logic [CH_BITS:0]   NUM_CH_L = (CH_BITS + 1)'(NUM_CH);

    state_t                  state;
    state_t                  state_nx;
    logic [WORD_WIDTH-1:0]   shreg;
    logic [CH_BITS-1:0]      ch_reg;
    logic [8:0]              cyc_cnt;
    logic [5:0]              bit_cnt;
    logic [3:0]              gap_cnt;
    logic                    armed;

    logic [CH_BITS-1:0]      head_ch;
    logic                    head_ok;
    logic                    bit_end;
    logic                    frame_end;
    logic                    gap_end;
    logic                    fetch;

    // Decode of the FIFO head and the counter terminal conditions
    always_comb begin
        head_ch   = data[CH_BITS+WORD_WIDTH-1:WORD_WIDTH];
        head_ok   = ({1'b0, head_ch} < NUM_CH_L);
        bit_end   = (cyc_cnt == LAST_CYC);
        frame_end = (state == SHIFT) && bit_end && (bit_cnt == LAST_BIT);
        gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
        // armed keeps the first cycle after reset release fetch-free
        fetch     = armed && start_transmit && !fifo_empty && ((state == IDLE) || gap_end);
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control pulses
    always_comb begin
        state_nx   = state;
        spi_busy   = (state != IDLE);
        fifo_read  = fetch;
        chan_error = fetch && !head_ok;
        frame_done = frame_end;
        case (state)
            IDLE: begin
                if (fetch) begin
                    state_nx = head_ok ? SHIFT : GAP;
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_end) begin
                    if (fetch) begin
                        state_nx = head_ok ? SHIFT : GAP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift register, channel latch and bit/cycle/gap counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            ch_reg  <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                SHIFT: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (LSB_FIRST != 0) begin
                            shreg <= {1'b0, shreg[WORD_WIDTH-1:1]};
                        end else begin
                            shreg <= {shreg[WORD_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 9'd1;
                    end
                    if (frame_end) begin
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                end
            endcase
            if (fetch) begin
                shreg   <= data[WORD_WIDTH-1:0];
                ch_reg  <= head_ch;
                cyc_cnt <= '0;
                bit_cnt <= '0;
                gap_cnt <= '0;
            end
        end
    end

    // Serial pins: only driven away from idle levels while shifting
    always_comb begin
        sync_n = '1;
        sclk   = CPOL_B;
        sdo    = 1'b0;
        if (state == SHIFT) begin
            sclk = (cyc_cnt < HALF_CNT) ? CPOL_B : ~CPOL_B;
            sdo  = (LSB_FIRST != 0) ? shreg[0] : shreg[WORD_WIDTH-1];
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_reg == CH_BITS'(i)) begin
                    sync_n[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_multichannel_transmitter.sv
// tb/tb_spi_multichannel_transmitter.sv - self-checking bench for spi_multichannel_transmitter
module tb_spi_multichannel_transmitter;

    localparam int WW_A = 24, CD_A = 1, NCH_A = 2, CPOL_A = 1, LSB_A = 0, SG_A = 2;
    localparam int WW_B = 16, CD_B = 3, NCH_B = 3, CPOL_B = 0, LSB_B = 1, SG_B = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [24:0] data_a;
    logic        fifo_empty_a, fifo_read_a, start_a, busy_a, done_a, cerr_a, sdo_a, sclk_a;
    logic [1:0]  sync_a;
    logic [17:0] data_b;
    logic        fifo_empty_b, fifo_read_b, start_b, busy_b, done_b, cerr_b, sdo_b, sclk_b;
    logic [2:0]  sync_b;

    spi_multichannel_transmitter #(
        .WORD_WIDTH(WW_A), .CLK_DIV(CD_A), .NUM_CH(NCH_A),
        .CPOL(CPOL_A), .LSB_FIRST(LSB_A), .SYNC_GAP(SG_A)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .data(data_a), .fifo_empty(fifo_empty_a),
        .fifo_read(fifo_read_a), .start_transmit(start_a), .spi_busy(busy_a),
        .frame_done(done_a), .chan_error(cerr_a), .sdo(sdo_a), .sclk(sclk_a), .sync_n(sync_a)
    );

    spi_multichannel_transmitter #(
        .WORD_WIDTH(WW_B), .CLK_DIV(CD_B), .NUM_CH(NCH_B),
        .CPOL(CPOL_B), .LSB_FIRST(LSB_B), .SYNC_GAP(SG_B)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .data(data_b), .fifo_empty(fifo_empty_b),
        .fifo_read(fifo_read_b), .start_transmit(start_b), .spi_busy(busy_b),
        .frame_done(done_b), .chan_error(cerr_b), .sdo(sdo_b), .sclk(sclk_b), .sync_n(sync_b)
    );

    typedef struct {
        logic [7:0]  pat;
        logic [31:0] bits;
        int          nbits;
        int          len;
        bit          done_ok;
        int          gap;
        int          start_cyc;
        int          sclk_err;
    } frame_t;

    frame_t      fr_a[$];
    frame_t      fr_b[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          pend_a, pend_b;

    bit     in_fr[2];
    frame_t cur[2];
    logic   prev_sc[2];
    int     high_run[2], run[2], reads[2], dones[2], cerrs[2];
    int     idle_err[2], multi[2], rd_empty[2], ce_cyc[2];

    task automatic fifo_upd();
        logic [31:0] h;
        fifo_empty_a = (q_a.size() == 0);
        h = 32'h0;
        if (q_a.size() > 0) h = q_a[0];
        data_a = h[24:0];
        fifo_empty_b = (q_b.size() == 0);
        h = 32'h0;
        if (q_b.size() > 0) h = q_b[0];
        data_b = h[17:0];
    endtask

    task automatic mon_clear();
        fr_a.delete();
        fr_b.delete();
        for (int d = 0; d < 2; d++) begin
            in_fr[d] = 0; high_run[d] = 100; run[d] = 0; reads[d] = 0; dones[d] = 0;
            cerrs[d] = 0; idle_err[d] = 0; multi[d] = 0; rd_empty[d] = 0; ce_cyc[d] = 0;
        end
        prev_sc[0] = 1'(CPOL_A);
        prev_sc[1] = 1'(CPOL_B);
    endtask

    // Protocol-level observer: reassembles frames from the pins as a receiver would
    task automatic mon(input int d, input logic [7:0] sn, input logic sc, input logic so,
                       input logic fd, input logic rd, input logic ce, input logic emp,
                       input logic cpol, input bit lsb, input int div);
        logic [7:0]  act;
        logic [31:0] b;
        act = ~sn;
        if ($countones(act) > 1) multi[d] = multi[d] + 1;
        if (rd) reads[d] = reads[d] + 1;
        if (rd && emp) rd_empty[d] = rd_empty[d] + 1;
        if (fd) dones[d] = dones[d] + 1;
        if (ce) begin
            cerrs[d] = cerrs[d] + 1;
            ce_cyc[d] = cyc;
        end
        if (act != 8'h0) begin
            if (!in_fr[d]) begin
                in_fr[d] = 1;
                cur[d].pat = sn; cur[d].bits = 32'h0; cur[d].nbits = 0; cur[d].len = 0;
                cur[d].done_ok = 0; cur[d].gap = high_run[d]; cur[d].start_cyc = cyc;
                cur[d].sclk_err = (sc !== cpol) ? 1 : 0;
                run[d] = 0;
            end else if (sn != cur[d].pat) begin
                multi[d] = multi[d] + 1;
            end
            cur[d].len = cur[d].len + 1;
            if (cur[d].len > 1 && sc == prev_sc[d]) begin
                run[d] = run[d] + 1;
            end else begin
                if (cur[d].len > 1 && run[d] != div) cur[d].sclk_err = cur[d].sclk_err + 1;
                run[d] = 1;
            end
            if (sc != cpol && prev_sc[d] == cpol && cur[d].nbits < 32) begin
                b = cur[d].bits;
                if (lsb) b[cur[d].nbits] = so;
                else b = {b[30:0], so};
                cur[d].bits = b;
                cur[d].nbits = cur[d].nbits + 1;
            end
            cur[d].done_ok = fd;
        end else begin
            if (in_fr[d]) begin
                if (run[d] != div) cur[d].sclk_err = cur[d].sclk_err + 1;
                if (d == 0) fr_a.push_back(cur[d]);
                else fr_b.push_back(cur[d]);
                in_fr[d] = 0;
                high_run[d] = 0;
            end
            high_run[d] = high_run[d] + 1;
            if (so !== 1'b0 || sc !== cpol || fd) idle_err[d] = idle_err[d] + 1;
        end
        prev_sc[d] = sc;
    endtask

    // One clock: observe at the falling edge, pop the FIFO models just after the rising edge
    task automatic tick();
        @(negedge clock);
        cyc = cyc + 1;
        mon(0, {6'h3f, sync_a}, sclk_a, sdo_a, done_a, fifo_read_a, cerr_a, fifo_empty_a, 1'(CPOL_A), LSB_A != 0, CD_A);
        mon(1, {5'h1f, sync_b}, sclk_b, sdo_b, done_b, fifo_read_b, cerr_b, fifo_empty_b, 1'(CPOL_B), LSB_B != 0, CD_B);
        pend_a = fifo_read_a;
        pend_b = fifo_read_b;
        @(posedge clock);
        #1;
        if (pend_a && q_a.size() > 0) void'(q_a.pop_front());
        if (pend_b && q_b.size() > 0) void'(q_b.pop_front());
        fifo_upd();
    endtask

    task automatic wait_idle(input int d, input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < max && ((d == 0) ? (busy_a || (start_a && !fifo_empty_a))
                                        : (busy_b || (start_b && !fifo_empty_b))));
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL wait_idle dut%0d: still busy after %0d cycles, required idle", d, n);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (sync_a !== 2'b11) begin errors++; $display("FAIL reset_sync_a: got %b want 11", sync_a); end
        checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL reset_sclk_a: got %b want 1", sclk_a); end
        checks++; if (sdo_a !== 1'b0) begin errors++; $display("FAIL reset_sdo_a: got %b want 0", sdo_a); end
        checks++; if (fifo_read_a !== 1'b0) begin errors++; $display("FAIL reset_read_a: got %b want 0", fifo_read_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        checks++; if ({done_a, cerr_a} !== 2'b00) begin errors++; $display("FAIL reset_pulses_a: got %b want 00", {done_a, cerr_a}); end
        checks++;
        if ({sync_b, sclk_b, sdo_b, busy_b} !== 6'b111000) begin
            errors++; $display("FAIL reset_b: got %b want 111000", {sync_b, sclk_b, sdo_b, busy_b});
        end
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single_frame();
        mon_clear();
        q_a.push_back({8'h00, 24'hEA3A35});
        fifo_upd();
        start_a = 1'b1;
        wait_idle(0, 200);
        start_a = 1'b0;
        checks++; if (fr_a.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", fr_a.size()); end
        if (fr_a.size() >= 1) begin
            checks++; if (fr_a[0].pat !== 8'hFE) begin errors++; $display("FAIL single_sync: got %h want fe", fr_a[0].pat); end
            checks++; if (fr_a[0].bits !== 32'h00EA3A35) begin errors++; $display("FAIL single_bits: got %h want ea3a35", fr_a[0].bits); end
            checks++; if (fr_a[0].nbits != 24) begin errors++; $display("FAIL single_nbits: got %0d want 24", fr_a[0].nbits); end
            checks++; if (fr_a[0].len != 48) begin errors++; $display("FAIL single_len: got %0d want 48", fr_a[0].len); end
            checks++; if (!fr_a[0].done_ok) begin errors++; $display("FAIL single_done_pos: got 0 want 1"); end
            checks++; if (fr_a[0].sclk_err != 0) begin errors++; $display("FAIL single_sclk: got %0d want 0", fr_a[0].sclk_err); end
        end
        checks++; if (reads[0] != 1) begin errors++; $display("FAIL single_reads: got %0d want 1", reads[0]); end
        checks++; if (dones[0] != 1) begin errors++; $display("FAIL single_dones: got %0d want 1", dones[0]); end
        checks++; if (idle_err[0] != 0) begin errors++; $display("FAIL single_idle_pins: got %0d want 0", idle_err[0]); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp[$];
        logic [31:0] w;
        logic [7:0]  ep;
        int n;
        mon_clear();
        n = 3 + int'($urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            w = $urandom & 32'h00FFFFFF;
            if (i == 1) w[24] = 1'b1;
            else if (i > 2) w[24] = 1'($urandom_range(0, 1));
            exp.push_back(w);
            q_a.push_back(w);
        end
        fifo_upd();
        start_a = 1'b1;
        wait_idle(0, 100 * n + 50);
        start_a = 1'b0;
        checks++; if (fr_a.size() != n) begin errors++; $display("FAIL b2b_count: got %0d want %0d", fr_a.size(), n); end
        for (int i = 0; i < n && i < fr_a.size(); i++) begin
            w = exp[i];
            ep = ~(8'h01 << w[24]);
            checks++; if (fr_a[i].pat !== ep) begin errors++; $display("FAIL b2b_sync[%0d]: got %h want %h", i, fr_a[i].pat, ep); end
            checks++; if (fr_a[i].bits !== {8'h00, w[23:0]}) begin errors++; $display("FAIL b2b_bits[%0d]: got %h want %h", i, fr_a[i].bits, w[23:0]); end
            checks++; if (fr_a[i].len != 48 || !fr_a[i].done_ok) begin errors++; $display("FAIL b2b_len[%0d]: got %0d/%0d want 48/1", i, fr_a[i].len, fr_a[i].done_ok); end
            if (i > 0) begin
                checks++; if (fr_a[i].gap != SG_A) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, fr_a[i].gap, SG_A); end
            end
        end
        checks++; if (reads[0] != n || dones[0] != n) begin errors++; $display("FAIL b2b_pulses: got %0d/%0d want %0d", reads[0], dones[0], n); end
        checks++; if (multi[0] != 0 || rd_empty[0] != 0 || idle_err[0] != 0) begin errors++; $display("FAIL b2b_rules: got %0d/%0d/%0d want 0", multi[0], rd_empty[0], idle_err[0]); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy_a); end
    endtask

    task automatic test_stop_mid();
        logic [31:0] w0;
        int k;
        mon_clear();
        w0 = $urandom & 32'h01FFFFFF;
        q_a.push_back(w0);
        q_a.push_back($urandom & 32'h01FFFFFF);
        fifo_upd();
        start_a = 1'b1;
        k = 0;
        while (sync_a === 2'b11 && k < 20) begin tick(); k++; end
        checks++; if (k >= 20) begin errors++; $display("FAIL stop_start: got no frame want frame within 20"); end
        repeat (10) tick();
        start_a = 1'b0;
        wait_idle(0, 200);
        checks++; if (fr_a.size() != 1) begin errors++; $display("FAIL stop_count: got %0d want 1", fr_a.size()); end
        if (fr_a.size() >= 1) begin
            checks++; if (fr_a[0].bits !== {8'h00, w0[23:0]} || !fr_a[0].done_ok) begin errors++; $display("FAIL stop_frame: got %h want %h", fr_a[0].bits, w0[23:0]); end
        end
        checks++; if (reads[0] != 1) begin errors++; $display("FAIL stop_reads: got %0d want 1", reads[0]); end
        checks++; if (q_a.size() != 1 || fifo_empty_a !== 1'b0) begin errors++; $display("FAIL stop_fifo: got %0d/%b want 1/0", q_a.size(), fifo_empty_a); end
        q_a.delete();
        fifo_upd();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1;
        int k;
        mon_clear();
        w1 = $urandom & 32'h01FFFFFF;
        q_a.push_back(32'h00FFFFFF);
        q_a.push_back(w1);
        fifo_upd();
        start_a = 1'b1;
        k = 0;
        while (sync_a === 2'b11 && k < 20) begin tick(); k++; end
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        checks++; if (sync_a !== 2'b11 || sclk_a !== 1'b1 || sdo_a !== 1'b0) begin errors++; $display("FAIL rstmid_pins: got %b/%b/%b want 11/1/0", sync_a, sclk_a, sdo_a); end
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b0 || fifo_read_a !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b/%b/%b want 0/0/0", done_a, busy_a, fifo_read_a); end
        tick();
        tick();
        reset_n = 1'b1;
        pend_a = 1'b0;
        pend_b = 1'b0;
        @(negedge clock);
        checks++; if (fifo_read_a !== 1'b0) begin errors++; $display("FAIL rstmid_wait: got %b want 0", fifo_read_a); end
        wait_idle(0, 200);
        start_a = 1'b0;
        checks++; if (fr_a.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", fr_a.size()); end
        if (fr_a.size() >= 2) begin
            checks++; if (fr_a[0].done_ok || fr_a[0].len >= 48) begin errors++; $display("FAIL rstmid_abort: got %0d/%0d want <48/0", fr_a[0].len, fr_a[0].done_ok); end
            checks++; if (fr_a[1].bits !== {8'h00, w1[23:0]} || fr_a[1].len != 48) begin errors++; $display("FAIL rstmid_next: got %h/%0d want %h/48", fr_a[1].bits, fr_a[1].len, w1[23:0]); end
        end
        checks++; if (dones[0] != 1 || reads[0] != 2) begin errors++; $display("FAIL rstmid_pulses: got %0d/%0d want 1/2", dones[0], reads[0]); end
    endtask

    task automatic test_chan_error();
        logic [31:0] g;
        logic [7:0]  ep;
        mon_clear();
        g = $urandom & 32'h0000FFFF;
        g[17:16] = 2'($urandom_range(0, 2));
        q_b.push_back({14'h0, 2'd3, 16'($urandom)});
        q_b.push_back(g);
        fifo_upd();
        start_b = 1'b1;
        wait_idle(1, 400);
        start_b = 1'b0;
        ep = ~(8'h01 << g[17:16]);
        checks++; if (cerrs[1] != 1) begin errors++; $display("FAIL cerr_count: got %0d want 1", cerrs[1]); end
        checks++; if (fr_b.size() != 1) begin errors++; $display("FAIL cerr_frames: got %0d want 1", fr_b.size()); end
        if (fr_b.size() >= 1) begin
            checks++; if (fr_b[0].pat !== ep || fr_b[0].bits !== {16'h0, g[15:0]}) begin errors++; $display("FAIL cerr_frame: got %h/%h want %h/%h", fr_b[0].pat, fr_b[0].bits, ep, g[15:0]); end
            checks++; if (fr_b[0].start_cyc - ce_cyc[1] != SG_B + 1) begin errors++; $display("FAIL cerr_gap: got %0d want %0d", fr_b[0].start_cyc - ce_cyc[1], SG_B + 1); end
        end
        checks++; if (idle_err[1] != 0 || reads[1] != 2 || dones[1] != 1) begin errors++; $display("FAIL cerr_pins: got %0d/%0d/%0d want 0/2/1", idle_err[1], reads[1], dones[1]); end
    endtask

    task automatic test_lsb_div();
        logic [31:0] w[2];
        mon_clear();
        w[0] = 32'h00008001;
        w[1] = {14'h0, 2'd2, 16'h1234};
        q_b.push_back(w[0]);
        q_b.push_back(w[1]);
        fifo_upd();
        start_b = 1'b1;
        wait_idle(1, 400);
        start_b = 1'b0;
        checks++; if (fr_b.size() != 2) begin errors++; $display("FAIL lsb_count: got %0d want 2", fr_b.size()); end
        if (fr_b.size() >= 2) begin
            checks++; if (fr_b[0].bits !== 32'h8001 || fr_b[0].pat !== 8'hFE) begin errors++; $display("FAIL lsb_f0: got %h/%h want 8001/fe", fr_b[0].bits, fr_b[0].pat); end
            checks++; if (fr_b[1].bits !== 32'h1234 || fr_b[1].pat !== 8'hFB) begin errors++; $display("FAIL lsb_f1: got %h/%h want 1234/fb", fr_b[1].bits, fr_b[1].pat); end
            for (int i = 0; i < 2; i++) begin
                checks++; if (fr_b[i].len != 96 || fr_b[i].nbits != 16 || !fr_b[i].done_ok) begin errors++; $display("FAIL lsb_len[%0d]: got %0d/%0d want 96/16", i, fr_b[i].len, fr_b[i].nbits); end
                checks++; if (fr_b[i].sclk_err != 0) begin errors++; $display("FAIL lsb_sclk[%0d]: got %0d want 0", i, fr_b[i].sclk_err); end
            end
            checks++; if (fr_b[1].gap != SG_B) begin errors++; $display("FAIL lsb_gap: got %0d want %0d", fr_b[1].gap, SG_B); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pend_a = 1'b0;
        pend_b = 1'b0;
        fifo_upd();
        mon_clear();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stop_mid();
        test_reset_mid();
        test_chan_error();
        test_lsb_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
